datapath2: RTL and testbench
============================

Name: datapath2

Overview:
Execute/memory/writeback half of the single-cycle MIPS core and the consumer side of datapath1. It takes PC, Instr, SrcA and WriteData from datapath1 and returns PCPlus4, PCTarget, PCSrc, Result and RegWrite. It contains the ALU, branch/jump target logic, a word-addressed data memory, and an iterative 32-cycle multiply/divide unit with HI/LO registers. The multiply/divide unit stalls the core through a Stall output.

Parameters:
DMEM_DEPTH, 256, number of 32-bit data memory words.
DMEM_AW, 8, data memory index width; equals log2(DMEM_DEPTH).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
PC  input  32  address of the current instruction.
Instr  input  32  current instruction word.
SrcA  input  32  rs register value.
WriteData  input  32  rt register value; also the store data.
PCPlus4  output  32  PC + 4.
PCTarget  output  32  branch or jump target.
PCSrc  output  1  1 selects PCTarget as the next PC.
Result  output  32  writeback value.
RegWrite  output  1  register file write enable.
Stall  output  1  1 means hold PC and suppress writeback.

Behaviour:
- Supported instructions:
  - R-type: add, sub, and, or, slt, mult, multu, div, divu, mfhi, mflo.
  - I-type: addi, lw, sw, beq.
  - J: j.
  - Any other opcode/funct: RegWrite=0, MemWrite=0, PCSrc=0.
- Arithmetic is 32-bit wraparound with no overflow traps. slt compares signed. The addi immediate is sign-extended.
- PCPlus4 = PC+4, modulo 2^32.
- beq: PCTarget = PCPlus4 + (sext(imm16)<<2).
- j: PCTarget = {PCPlus4[31:28], addr26, 2'b00}.
- PCSrc = (beq & SrcA==WriteData) | j.
- Data memory:
  - Combinational read.
  - Synchronous write on the clk rising edge when sw is decoded and Stall=0.
  - Index = ALUResult[DMEM_AW+1:2]. Upper address bits are ignored (wraps), and the low 2 bits are ignored.
  - Memory contents are not reset.
- Result mux: lw gives memory data; mfhi gives HI; mflo gives LO; otherwise ALUResult.
- Mult/div FSM, states IDLE, BUSY, DONE; reset state IDLE:
  - IDLE: if Instr is mult/multu/div/divu, Stall=1 combinationally. Latch operands (magnitudes and signs for the signed ops), count=0, go to BUSY.
  - BUSY: Stall=1. One shift-add (mult) or restoring-subtract (div) iteration per cycle. When count==31, write HI/LO and go to DONE.
  - DONE: Stall=0, so the instruction retires and PC advances. Go to IDLE next cycle. DONE never re-triggers on the same Instr.
  - Total stall: 33 cycles; the instruction retires on the 34th cycle.
- Mult/div results:
  - mult/multu: {HI,LO} = 64-bit product. Signed product is negated when the operand signs differ.
  - div/divu: LO = quotient, HI = remainder. Signed: quotient sign = sA^sB, remainder sign = sA.
  - Divide by zero: LO=32'hFFFFFFFF, HI=dividend (unsigned magnitude result; sign fixed as above).
- While Stall=1: RegWrite=0, PCSrc=0, memory write suppressed.
- mfhi/mflo always read the committed HI/LO. They cannot observe partial values because the core is stalled during BUSY.
- Reset (rst=0), asynchronous and valid at any time including mid-BUSY:
  - FSM=IDLE, count=0, HI=0, LO=0, operand registers=0.
  - While rst=0: Stall=0, RegWrite=0, PCSrc=0, no memory write.
  - After release, a muldiv Instr still present restarts from IDLE.

Test Plan:
1. rst=0 at t=0, release at 10 ns. Then add with SrcA=5, WriteData=7 -> Result=12, RegWrite=1, Stall=0, PCSrc=0, PCPlus4=PC+4.
2. sw (imm=8, SrcA=0x100, WriteData=32'hDEADBEEF), then lw at the same address -> Result=32'hDEADBEEF. A write with Stall=1 must leave memory unchanged.
3. beq, PC=0x10, imm=3, equal operands -> PCSrc=1, PCTarget=0x20. Unequal operands -> PCSrc=0. j with addr26=0x4 -> PCTarget=0x10.
4. mult, SrcA=-3, WriteData=7 -> Stall high for exactly 33 cycles. Then HI=32'hFFFFFFFF, LO=32'hFFFFFFEB, and mflo returns 32'hFFFFFFEB.
5. div, SrcA=-7, WriteData=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. divu by 0 with SrcA=9 -> LO=32'hFFFFFFFF, HI=9.
6. Assert rst=0 on the 10th BUSY cycle of multu -> Stall drops immediately, HI=LO=0. After release, the same Instr restarts a full 33-cycle stall.

Source files
------------

// File: rtl/datapath2.sv
// Execute/memory/writeback half of the single-cycle MIPS core: ALU, branch/jump, data memory, mul/div.
// Single cycle except mult/div, which hold Stall high for 33 cycles and retire on the 34th.
module datapath2 #(
  parameter int DMEM_DEPTH = 256,
  parameter int DMEM_AW    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic [31:0] Instr,
  input  logic [31:0] SrcA,
  input  logic [31:0] WriteData,
  output logic [31:0] PCPlus4,
  output logic [31:0] PCTarget,
  output logic        PCSrc,
  output logic [31:0] Result,
  output logic        RegWrite,
  output logic        Stall
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  logic [5:0]  op, fn;
  logic        is_r, is_add, is_sub, is_and, is_or, is_slt;
  logic        is_mult, is_multu, is_div, is_divu, is_mfhi, is_mflo, is_md;
  logic        is_addi, is_lw, is_sw, is_beq, is_j;
  logic [31:0] imm_ext, alu_b, alu_res, mem_rdata;
  logic        active, mem_we;

  md_state_t   state;
  logic [4:0]  count;
  logic [31:0] hi, lo, acc_hi, acc_lo, opb;
  logic        md_div, neg_q, neg_r;

  logic        md_signed, sa, sb;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum, div_sh;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [31:0] nxt_hi, nxt_lo, quo_fix, rem_fix;
  logic [63:0] prod_fix;

  logic [31:0] dmem [DMEM_DEPTH];

  assign op = Instr[31:26];
  assign fn = Instr[5:0];

  assign is_r     = (op == 6'h00);
  assign is_add   = is_r && (fn == 6'h20);
  assign is_sub   = is_r && (fn == 6'h22);
  assign is_and   = is_r && (fn == 6'h24);
  assign is_or    = is_r && (fn == 6'h25);
  assign is_slt   = is_r && (fn == 6'h2A);
  assign is_mult  = is_r && (fn == 6'h18);
  assign is_multu = is_r && (fn == 6'h19);
  assign is_div   = is_r && (fn == 6'h1A);
  assign is_divu  = is_r && (fn == 6'h1B);
  assign is_mfhi  = is_r && (fn == 6'h10);
  assign is_mflo  = is_r && (fn == 6'h12);
  assign is_addi  = (op == 6'h08);
  assign is_lw    = (op == 6'h23);
  assign is_sw    = (op == 6'h2B);
  assign is_beq   = (op == 6'h04);
  assign is_j     = (op == 6'h02);
  assign is_md    = is_mult || is_multu || is_div || is_divu;

  assign imm_ext = {{16{Instr[15]}}, Instr[15:0]};
  assign alu_b   = is_r ? WriteData : imm_ext;

  always_comb begin
    alu_res = SrcA + alu_b;
    if (is_sub)      alu_res = SrcA - WriteData;
    else if (is_and) alu_res = SrcA & WriteData;
    else if (is_or)  alu_res = SrcA | WriteData;
    else if (is_slt) alu_res = {31'd0, $signed(SrcA) < $signed(WriteData)};
  end

  assign PCPlus4  = PC + 32'd4;
  assign PCTarget = is_j ? {PCPlus4[31:28], Instr[25:0], 2'b00}
                         : PCPlus4 + {imm_ext[29:0], 2'b00};

  // Only the signed ops treat the top bit as a sign; the iteration always runs on magnitudes.
  assign md_signed = is_mult || is_div;
  assign sa        = md_signed && SrcA[31];
  assign sb        = md_signed && WriteData[31];
  assign mag_a     = sa ? (32'd0 - SrcA) : SrcA;
  assign mag_b     = sb ? (32'd0 - WriteData) : WriteData;

  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : 33'd0);
  assign div_sh   = {acc_hi, acc_lo[31]};
  assign div_ge   = (div_sh >= {1'b0, opb});
  assign div_diff = div_sh[31:0] - opb;

  always_comb begin
    if (md_div) begin
      nxt_hi = div_ge ? div_diff : div_sh[31:0];
      nxt_lo = {acc_lo[30:0], div_ge};
    end else begin
      nxt_hi = mul_sum[32:1];
      nxt_lo = {mul_sum[0], acc_lo[31:1]};
    end
  end

  assign prod_fix = neg_q ? (64'd0 - {nxt_hi, nxt_lo}) : {nxt_hi, nxt_lo};
  assign quo_fix  = neg_q ? (32'd0 - nxt_lo) : nxt_lo;
  assign rem_fix  = neg_r ? (32'd0 - nxt_hi) : nxt_hi;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= 5'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      acc_hi <= 32'd0;
      acc_lo <= 32'd0;
      opb    <= 32'd0;
      md_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_md) begin
            state  <= BUSY;
            count  <= 5'd0;
            acc_hi <= 32'd0;
            md_div <= is_div || is_divu;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            if (is_div || is_divu) begin
              acc_lo <= mag_a;
              opb    <= mag_b;
            end else begin
              acc_lo <= mag_b;
              opb    <= mag_a;
            end
          end
        end
        BUSY: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          count  <= count + 5'd1;
          if (count == 5'd31) begin
            state <= DONE;
            if (md_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[63:32];
              lo <= prod_fix[31:0];
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign Stall    = rst && ((state == BUSY) || ((state == IDLE) && is_md));
  assign active   = rst && !Stall;
  assign RegWrite = active && (is_add || is_sub || is_and || is_or || is_slt ||
                               is_mfhi || is_mflo || is_addi || is_lw);
  assign PCSrc    = active && ((is_beq && (SrcA == WriteData)) || is_j);
  assign mem_we   = active && is_sw;

  // Word index only: byte offset and address bits above the array wrap away.
  assign mem_rdata = dmem[alu_res[DMEM_AW+1:2]];

  always_ff @(posedge clk) begin
    if (mem_we) dmem[alu_res[DMEM_AW+1:2]] <= WriteData;
  end

  always_comb begin
    Result = alu_res;
    if (is_lw)        Result = mem_rdata;
    else if (is_mfhi) Result = hi;
    else if (is_mflo) Result = lo;
  end

endmodule

// File: tb/tb_datapath2.sv
// Bench for datapath2: directed cases then random instructions against a behavioural model,
// expectations queued at issue and compared by a monitor when the instruction retires.
module tb_datapath2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PC = 32'd0, Instr = 32'd0, SrcA = 32'd0, WriteData = 32'd0;
  logic [31:0] PCPlus4, PCTarget, Result;
  logic        PCSrc, RegWrite, Stall;

  datapath2 #(.DMEM_DEPTH(256), .DMEM_AW(8)) dut (
    .clk(clk), .rst(rst), .PC(PC), .Instr(Instr), .SrcA(SrcA), .WriteData(WriteData),
    .PCPlus4(PCPlus4), .PCTarget(PCTarget), .PCSrc(PCSrc), .Result(Result),
    .RegWrite(RegWrite), .Stall(Stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        chk_res;
    logic        regw;
    logic        pcsrc;
    logic        chk_tgt;
    logic [31:0] tgt;
    logic [31:0] pc4;
    int          stalls;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          nid = 0;
  logic [31:0] mem_m [256];
  logic [31:0] hi_m = 32'd0, lo_m = 32'd0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s instr#%0d actual=%08h expected=%08h", nm, id, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] f);
    return {6'h00, 5'($urandom), 5'($urandom), 5'($urandom), 5'h00, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] o, input logic [15:0] imm);
    return {o, 10'($urandom), imm};
  endfunction

  // Architectural reference: plain arithmetic on the instruction's meaning.
  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] ins,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [5:0]  o, f;
    logic [31:0] simm, addr;
    logic [63:0] p;
    longint      sq, sr;
    int          idx;
    e.id = nid; e.res = 32'd0; e.chk_res = 1'b0; e.regw = 1'b0; e.pcsrc = 1'b0;
    e.chk_tgt = 1'b0; e.tgt = 32'd0; e.pc4 = pc + 32'd4; e.stalls = 0;
    o = ins[31:26]; f = ins[5:0];
    simm = {{16{ins[15]}}, ins[15:0]};
    addr = a + simm;
    idx  = int'(addr[9:2]);
    if (o == 6'h00) begin
      case (f)
        6'h20: begin e.res = a + b; e.regw = 1'b1; end
        6'h22: begin e.res = a - b; e.regw = 1'b1; end
        6'h24: begin e.res = a & b; e.regw = 1'b1; end
        6'h25: begin e.res = a | b; e.regw = 1'b1; end
        6'h2A: begin e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; e.regw = 1'b1; end
        6'h10: begin e.res = hi_m; e.regw = 1'b1; end
        6'h12: begin e.res = lo_m; e.regw = 1'b1; end
        6'h18: begin
          p = 64'(longint'($signed(a)) * longint'($signed(b)));
          hi_m = p[63:32]; lo_m = p[31:0]; e.stalls = 33;
        end
        6'h19: begin
          p = {32'd0, a} * {32'd0, b};
          hi_m = p[63:32]; lo_m = p[31:0]; e.stalls = 33;
        end
        6'h1A: begin
          if (b == 32'd0) begin
            lo_m = a[31] ? 32'd1 : 32'hFFFFFFFF;
            hi_m = a;
          end else begin
            sq = longint'($signed(a)) / longint'($signed(b));
            sr = longint'($signed(a)) % longint'($signed(b));
            lo_m = 32'(sq); hi_m = 32'(sr);
          end
          e.stalls = 33;
        end
        6'h1B: begin
          if (b == 32'd0) begin
            lo_m = 32'hFFFFFFFF; hi_m = a;
          end else begin
            lo_m = a / b; hi_m = a % b;
          end
          e.stalls = 33;
        end
        default: ;
      endcase
    end else begin
      case (o)
        6'h08: begin e.res = addr; e.regw = 1'b1; end
        6'h23: begin e.res = mem_m[idx]; e.regw = 1'b1; end
        6'h2B: mem_m[idx] = b;
        6'h04: begin e.chk_tgt = 1'b1; e.tgt = pc + 32'd4 + (simm << 2); e.pcsrc = (a == b); end
        6'h02: begin
          e.chk_tgt = 1'b1; e.pcsrc = 1'b1;
          e.tgt = {e.pc4[31:28], ins[25:0], 2'b00};
        end
        default: ;
      endcase
    end
    e.chk_res = e.regw;
    return e;
  endfunction

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] a, input logic [31:0] b);
    PC = pc; Instr = ins; SrcA = a; WriteData = b;
    sb.push_back(model(pc, ins, a, b));
    nid++;
  endtask

  task automatic wait_retire();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rst && !Stall) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL retire_timeout instr#%0d actual=stalled expected=retire", nid - 1);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] a, input logic [31:0] b);
    drive(pc, ins, a, b);
    wait_retire();
  endtask

  // Monitor: counts stalled cycles and checks each instruction as it retires.
  initial begin
    exp_t me;
    int   stall_run = 0;
    forever begin
      @(negedge clk);
      if (!rst) stall_run = 0;
      else if (Stall) stall_run++;
      else if (sb.size() != 0) begin
        me = sb.pop_front();
        if (me.chk_res) chk("result", me.id, Result, me.res);
        chk("regwrite", me.id, 32'(RegWrite), 32'(me.regw));
        chk("pcsrc", me.id, 32'(PCSrc), 32'(me.pcsrc));
        chk("pcplus4", me.id, PCPlus4, me.pc4);
        if (me.chk_tgt) chk("pctarget", me.id, PCTarget, me.tgt);
        chk("stall_cycles", me.id, 32'(stall_run), 32'(me.stalls));
        stall_run = 0;
      end else stall_run = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, ins, pc;
    int          k;

    // Reset: a muldiv instruction must not stall while rst is low.
    Instr = rtype(6'h18); SrcA = 32'd3; WriteData = 32'd4;
    #2;
    chk("reset_stall", -1, 32'(Stall), 32'd0);
    chk("reset_regwrite", -1, 32'(RegWrite), 32'd0);
    chk("reset_pcsrc", -1, 32'(PCSrc), 32'd0);
    Instr = 32'd0;
    #8 rst = 1'b1;
    @(posedge clk); #1;

    issue(32'h0000_0040, rtype(6'h20), 32'd5, 32'd7);
    issue(32'h0000_0044, rtype(6'h10), 32'd0, 32'd0);
    issue(32'h0000_0048, rtype(6'h12), 32'd0, 32'd0);

    issue(32'h0000_0050, itype(6'h2B, 16'd8), 32'h100, 32'hDEADBEEF);
    issue(32'h0000_0054, itype(6'h23, 16'd8), 32'h100, 32'd0);
    // A store presented while the mul/div unit is busy must not land.
    drive(32'h0000_0058, rtype(6'h18), 32'd11, 32'd13);
    repeat (5) @(posedge clk);
    #1 Instr = itype(6'h2B, 16'd8); SrcA = 32'h100; WriteData = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1 Instr = rtype(6'h18); SrcA = 32'd11; WriteData = 32'd13;
    wait_retire();
    issue(32'h0000_005C, itype(6'h23, 16'd8), 32'h100, 32'd0);

    issue(32'h0000_0010, itype(6'h04, 16'd3), 32'h55, 32'h55);
    issue(32'h0000_0010, itype(6'h04, 16'd3), 32'd1, 32'd2);
    issue(32'h0000_0000, {6'h02, 26'h4}, 32'd0, 32'd0);

    issue(32'h0000_0060, rtype(6'h18), 32'hFFFFFFFD, 32'd7);
    issue(32'h0000_0064, rtype(6'h10), 32'd0, 32'd0);
    issue(32'h0000_0068, rtype(6'h12), 32'd0, 32'd0);

    issue(32'h0000_0070, rtype(6'h1A), 32'hFFFFFFF9, 32'd2);
    issue(32'h0000_0074, rtype(6'h12), 32'd0, 32'd0);
    issue(32'h0000_0078, rtype(6'h10), 32'd0, 32'd0);
    issue(32'h0000_007C, rtype(6'h1B), 32'd9, 32'd0);
    issue(32'h0000_0080, rtype(6'h12), 32'd0, 32'd0);
    issue(32'h0000_0084, rtype(6'h10), 32'd0, 32'd0);

    // Reset in the middle of a multu, then let the same instruction run again.
    drive(32'h0000_0090, rtype(6'h19), 32'hF000_0001, 32'h0000_0123);
    repeat (11) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    #1 chk("midbusy_reset_stall", -1, 32'(Stall), 32'd0);
    chk("midbusy_reset_regwrite", -1, 32'(RegWrite), 32'd0);
    Instr = rtype(6'h10);
    #1 chk("reset_hi", -1, Result, 32'd0);
    Instr = rtype(6'h12);
    #1 chk("reset_lo", -1, Result, 32'd0);
    Instr = rtype(6'h19);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    void'(model(32'h0000_0090, rtype(6'h19), 32'hF000_0001, 32'h0000_0123));
    wait_retire();
    issue(32'h0000_0094, rtype(6'h10), 32'd0, 32'd0);
    issue(32'h0000_0098, rtype(6'h12), 32'd0, 32'd0);

    for (int i = 0; i < 256; i++) issue(32'h0000_1000, itype(6'h2B, 16'd0), 32'(i * 4), $urandom);

    for (int n = 0; n < 300; n++) begin
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 20)) - 32'd10;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 20)) - 32'd10;
      if ($urandom_range(0, 4) == 0) b = a;
      pc = $urandom & 32'hFFFF_FFFC;
      k = $urandom_range(0, 16);
      case (k)
        0:  ins = rtype(6'h20);
        1:  ins = rtype(6'h22);
        2:  ins = rtype(6'h24);
        3:  ins = rtype(6'h25);
        4:  ins = rtype(6'h2A);
        5:  ins = rtype(6'h18);
        6:  ins = rtype(6'h19);
        7:  ins = rtype(6'h1A);
        8:  ins = rtype(6'h1B);
        9:  ins = rtype(6'h10);
        10: ins = rtype(6'h12);
        11: ins = itype(6'h08, 16'($urandom));
        12: ins = itype(6'h23, 16'($urandom));
        13: ins = itype(6'h2B, 16'($urandom));
        14: ins = itype(6'h04, 16'($urandom));
        15: ins = {6'h02, 26'($urandom)};
        default: ins = ($urandom_range(0, 1) == 0) ? rtype(6'h3F) : itype(6'h3F, 16'($urandom));
      endcase
      if ((k == 7 || k == 8) && $urandom_range(0, 4) == 0) b = 32'd0;
      issue(pc, ins, a, b);
    end

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
